main_mem_resp: RTL and testbench

Main-memory responder that services cache-line refill and write-back requests issued by the data cache inside the CPU's memory/MMIO stage on a miss. It holds a word-addressed backing store, models a fixed access latency, then streams one 32-bit word per cycle in a burst of one line. It also exposes a combinational debug read port for the SDU and optional request counters.

---
 rtl/main_mem_pkg.sv | 16 +
 rtl/main_mem_array.sv | 29 ++
 rtl/main_mem_resp.sv | 137 +++++++++++++
 tb/tb_main_mem_resp.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/main_mem_pkg.sv
// Shared definitions for the main-memory responder and the data cache that talks to it.
package main_mem_pkg;

  localparam int unsigned DefLineWords = 4;
  localparam int unsigned DefLatency   = 3;
  localparam int unsigned LINE_OFF_W   = $clog2(DefLineWords);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StBurst = 2'd2;

  function automatic int unsigned line_off_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

endpackage

// File: rtl/main_mem_array.sv
// Word-addressed backing store: one synchronous write port, asynchronous burst and debug reads.
module main_mem_array #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o,
  input  logic [ADDR_W-1:0] daddr_i,
  output logic [31:0]       ddata_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  // No reset: contents survive rstn so a partial write-back stays visible.
  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
  assign ddata_o = mem_q[daddr_i];

endmodule

// File: rtl/main_mem_resp.sv
// Main-memory responder: fixed-latency line refill / write-back bursts plus a debug read port.
// Request counters are built only when MAIN_MEM_RESP_STAT_EN is defined.
module main_mem_resp
  import main_mem_pkg::*;
#(
  parameter int unsigned LINE_WORDS = DefLineWords,
  parameter int unsigned LATENCY    = DefLatency,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic        mem_rvalid,
  output logic [31:0] mem_rdata,
  output logic        mem_wnext,
  output logic        mem_last,
  input  logic [31:0] dbg_addr,
  output logic [31:0] dbg_data,
  output logic [31:0] stat_rd_req,
  output logic [31:0] stat_wr_req
);

  localparam int unsigned OffW  = line_off_w(LINE_WORDS);
  localparam int unsigned BaseW = ADDR_W - OffW;
  localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [OffW-1:0]  beat_q, beat_d;
  logic [BaseW-1:0] base_q, base_d;
  logic             we_q, we_d;
  logic             accept, burst, last_beat;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]      arr_rdata;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[OffW+1:0], dbg_addr[31:ADDR_W]};

  assign mem_ready = (state_q == StIdle);
  assign accept    = mem_req && mem_ready;
  assign burst     = (state_q == StBurst);
  assign last_beat = (beat_q == OffW'(LINE_WORDS - 1));
  assign word_addr = {base_q, beat_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    base_d  = base_q;
    we_d    = we_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StWait;
          base_d  = mem_addr[ADDR_W+1:OffW+2];
          we_d    = mem_we;
          cnt_d   = CntW'(LATENCY - 1);
          beat_d  = '0;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StBurst;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StBurst: begin
        beat_d = beat_q + 1'b1;
        if (last_beat) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      beat_q  <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      we_q    <= we_d;
    end
  end

  assign mem_rvalid = burst && !we_q;
  assign mem_wnext  = burst && we_q;
  assign mem_last   = burst && last_beat;
  assign mem_rdata  = mem_rvalid ? arr_rdata : '0;

  main_mem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_wnext),
    .waddr_i (word_addr),
    .wdata_i (mem_wdata),
    .raddr_i (word_addr),
    .rdata_o (arr_rdata),
    .daddr_i (dbg_addr[ADDR_W-1:0]),
    .ddata_o (dbg_data)
  );

`ifdef MAIN_MEM_RESP_STAT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  // Saturating so a long-running SDU session never sees the count wrap to a small value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (accept) begin
      if (!mem_we && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (mem_we && (wr_cnt_q != '1))  wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign stat_rd_req = rd_cnt_q;
  assign stat_wr_req = wr_cnt_q;
`else
  assign stat_rd_req = '0;
  assign stat_wr_req = '0;
`endif

endmodule

// File: tb/tb_main_mem_resp.sv
// Directed + randomized bench for main_mem_resp against a word-level reference store.
module tb_main_mem_resp;

  localparam int unsigned LW    = 4;
  localparam int unsigned LAT   = 3;
  localparam int unsigned AW    = 10;
  localparam int unsigned Depth = 1 << AW;
  localparam int unsigned Per   = LAT + LW + 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] dbg_addr = '0;
  logic        mem_ready, mem_rvalid, mem_wnext, mem_last;
  logic [31:0] mem_rdata, dbg_data, stat_rd_req, stat_wr_req;

  int checks = 0;
  int failures = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  logic [31:0] model [int unsigned];
  logic [31:0] wbuf [LW];
  logic [31:0] lines [$];

  main_mem_resp #(
    .LINE_WORDS(LW),
    .LATENCY   (LAT),
    .ADDR_W    (AW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_wnext  (mem_wnext),
    .mem_last   (mem_last),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .stat_rd_req(stat_rd_req),
    .stat_wr_req(stat_wr_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Word address of beat b of the line holding byte_addr, wrapped to the store depth.
  function automatic int unsigned word_of(input logic [31:0] byte_addr, input int b);
    int unsigned line;
    line = (byte_addr >> 2) & ~(LW - 1);
    return (line + b) % Depth;
  endfunction

  function automatic logic [31:0] exp_stat(input int n);
`ifdef MAIN_MEM_RESP_STAT_EN
    return n;
`else
    return (n > 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_hs"}, {28'd0, mem_ready, mem_rvalid, mem_wnext, mem_last}, 32'h8);
    chk({tag, "_rdata"}, mem_rdata, 32'd0);
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_rd"}, stat_rd_req, exp_stat(exp_rd));
    chk({tag, "_wr"}, stat_wr_req, exp_stat(exp_wr));
  endtask

  // One line transfer; abort_beat >= 0 pulls rstn right after that beat's write edge.
  task automatic xfer(input bit we, input logic [31:0] addr, input int abort_beat);
    int waited;
    waited = 0;
    @(posedge clk); #1;
    mem_req = 1'b1;
    mem_we = we;
    mem_addr = addr;
    @(negedge clk);
    while (!mem_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_ready", {31'd0, mem_ready}, 32'd1);
    @(posedge clk); #1;
    mem_req = 1'b0;
    mem_addr = $urandom;
    mem_we = ~we;
    if (we) exp_wr++; else exp_rd++;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      chk("wait_hs", {28'd0, mem_ready, mem_rvalid, mem_wnext, mem_last}, 32'd0);
      @(posedge clk); #1;
    end
    for (int b = 0; b < LW; b++) begin
      int unsigned w;
      w = word_of(addr, b);
      mem_wdata = wbuf[b];
      dbg_addr = w;
      @(negedge clk);
      chk("beat_hs", {28'd0, mem_ready, mem_rvalid, mem_wnext, mem_last},
          {28'd0, 1'b0, !we, we, (b == LW - 1)});
      if (!we) chk("rdata", mem_rdata, model[w]);
      if (we && model.exists(w)) chk("dbg_old", dbg_data, model[w]);
      @(posedge clk);
      if (we) model[w] = wbuf[b];
      if (b == abort_beat) begin
        #1 rstn = 1'b0;
        #1 check_idle("rst_idle");
        exp_rd = 0;
        exp_wr = 0;
        #2 rstn = 1'b1;
        check_stats("rst_stat");
        return;
      end
      #1;
    end
    @(negedge clk);
    check_idle("ready_back");
  endtask

  initial begin
    int beats;
    // Reset state
    #2;
    check_idle("reset");
    check_stats("reset_stat");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Write-back A0..A3 to 0x100, then debug reads of words 0x40..0x43
    for (int b = 0; b < LW; b++) wbuf[b] = 32'hA0 + b;
    xfer(1'b1, 32'h0000_0100, -1);
    for (int b = 0; b < LW; b++) begin
      dbg_addr = 32'h40 + b;
      #1 chk("dbg_a", dbg_data, 32'hA0 + b);
    end

    // Refill of the same line
    xfer(1'b0, 32'h0000_0100, -1);
    check_stats("stat1");

    // Request held across two refills: second accept on first idle cycle, 8 beats
    @(posedge clk); #1;
    mem_req = 1'b1;
    mem_we = 1'b0;
    mem_addr = 32'h0000_0100;
    beats = 0;
    for (int k = 0; k < 2 * Per; k++) begin
      int ph;
      ph = k % Per;
      if (k == 2 * Per - 1) mem_req = 1'b0;
      @(negedge clk);
      chk("b2b_ready", {31'd0, mem_ready}, {31'd0, ph == 0});
      if (mem_rvalid) begin
        beats++;
        chk("b2b_rdata", mem_rdata, model[word_of(32'h100, ph - LAT - 1)]);
      end
      @(posedge clk); #1;
    end
    exp_rd += 2;
    chk("b2b_beats", beats, 2 * LW);
    @(negedge clk);
    check_idle("b2b_end");
    @(negedge clk);
    check_idle("b2b_noacc");
    check_stats("stat2");

    // Preload 0x200 line, then reset lands right after beat 1 of B0..B3 write-back
    for (int b = 0; b < LW; b++) wbuf[b] = $urandom;
    xfer(1'b1, 32'h0000_0200, -1);
    for (int b = 0; b < LW; b++) wbuf[b] = 32'hB0 + b;
    xfer(1'b1, 32'h0000_0200, 1);
    for (int b = 0; b < LW; b++) begin
      dbg_addr = 32'h80 + b;
      #1 chk("dbg_part", dbg_data, model[32'h80 + b]);
    end
    dbg_addr = 32'h81;
    #1 chk("dbg_b1", dbg_data, 32'hB1);
    @(negedge clk);
    check_idle("post_rst");

    // Aliasing: 0x1000 wraps to word 0
    for (int b = 0; b < LW; b++) wbuf[b] = $urandom;
    xfer(1'b1, 32'h0000_1000, -1);
    dbg_addr = 32'h0;
    #1 chk("alias_dbg", dbg_data, wbuf[0]);
    xfer(1'b0, 32'h0000_0000, -1);

    // Randomized lines written then read back in random order
    repeat (4) begin
      logic [31:0] a;
      a = $urandom;
      for (int b = 0; b < LW; b++) wbuf[b] = $urandom;
      xfer(1'b1, a, -1);
      lines.push_back(a);
    end
    repeat (4) xfer(1'b0, lines[$urandom_range(0, 3)], -1);
    check_stats("stat3");

    // Fresh reset, then 3 refills and 2 write-backs
    @(negedge clk) rstn = 1'b0;
    #2 rstn = 1'b1;
    exp_rd = 0;
    exp_wr = 0;
    check_stats("stat_clr");
    for (int i = 0; i < 3; i++) xfer(1'b0, lines[i], -1);
    for (int i = 0; i < 2; i++) begin
      for (int b = 0; b < LW; b++) wbuf[b] = $urandom;
      xfer(1'b1, $urandom, -1);
    end
    chk("stat_rd3", stat_rd_req, exp_stat(3));
    chk("stat_wr2", stat_wr_req, exp_stat(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
